// File: rtl/sd_clock_divider_pkg.sv
// Shared types and helpers for the multi-channel sigma-delta clock divider.
// Holds the per-channel state encoding, the config record used for
// validity checks, and the default reset ratio (100 MHz -> 16 MHz).
package sd_clock_divider_pkg;

  // Per-channel phase state; clk_out is high only in ST_HIGH.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } chan_state_e;

  // Config fields are carried zero-extended to this width for checking.
  localparam int CFG_FIELD_W = 32;

  typedef struct packed {
    logic [CFG_FIELD_W-1:0] half;
    logic [CFG_FIELD_W-1:0] num;
    logic [CFG_FIELD_W-1:0] den;
  } ratio_cfg_t;

  // Reset ratio: 3 + 1/8 input cycles per half-period.
  localparam int DEFAULT_RESET_HALF = 3;
  localparam int DEFAULT_RESET_NUM  = 1;
  localparam int DEFAULT_RESET_DEN  = 8;

  // A ratio is usable when the integer part is non-zero and the
  // fraction is a proper fraction with a non-zero denominator.
  function automatic logic cfg_is_valid(input ratio_cfg_t cfg);
    return (cfg.half != '0) && (cfg.den != '0) && (cfg.num < cfg.den);
  endfunction

endpackage

// File: rtl/sd_clock_divider_chan.sv
// One output channel of the fractional clock divider: phase FSM,
// half-period down-counter, sigma accumulator and a one-deep shadow
// register for glitch-free ratio changes at rising-edge boundaries.
module sd_clock_divider_chan
  import sd_clock_divider_pkg::*;
#(
  parameter int HALF_W     = 16,
  parameter int FRAC_W     = 16,
  parameter int RESET_HALF = DEFAULT_RESET_HALF,
  parameter int RESET_NUM  = DEFAULT_RESET_NUM,
  parameter int RESET_DEN  = DEFAULT_RESET_DEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic              wr,
  input  logic [HALF_W-1:0] wr_half,
  input  logic [FRAC_W-1:0] wr_num,
  input  logic [FRAC_W-1:0] wr_den,
  output logic              shadow_full,
  output logic              clk_out,
  output logic              rise_stb
);

  chan_state_e       state_reg, state_next;
  logic [HALF_W-1:0] cnt_reg, cnt_next;
  logic [FRAC_W-1:0] sigma_reg, sigma_next;
  logic [HALF_W-1:0] act_half_reg, act_half_next;
  logic [FRAC_W-1:0] act_num_reg, act_num_next;
  logic [FRAC_W-1:0] act_den_reg, act_den_next;
  logic [HALF_W-1:0] shd_half_reg, shd_half_next;
  logic [FRAC_W-1:0] shd_num_reg, shd_num_next;
  logic [FRAC_W-1:0] shd_den_reg, shd_den_next;
  logic              shd_full_reg, shd_full_next;
  logic              clk_out_reg;
  logic              rise_reg;

  // Transition decisions for this cycle.
  logic start_high, start_low, go_idle, count_down, idle_apply;
  logic apply_shadow, restart_sigma;

  // Phase-start arithmetic operands and results.
  logic [HALF_W-1:0] ph_half;
  logic [FRAC_W-1:0] ph_num, ph_den, ph_sigma_base;
  logic [FRAC_W:0]   ph_sum;
  logic              ph_ext;
  logic [FRAC_W-1:0] ph_sigma;
  logic [HALF_W-1:0] ph_cnt;

  // Decide what the channel does this cycle; sync overrides counter expiry.
  always_comb begin
    start_high = 1'b0;
    start_low  = 1'b0;
    go_idle    = 1'b0;
    count_down = 1'b0;
    idle_apply = 1'b0;
    if (sync && en) begin
      start_high = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (en) begin
            start_high = 1'b1;
          end else begin
            go_idle    = 1'b1;
            idle_apply = shd_full_reg;
          end
        end
        ST_HIGH: begin
          // A dropped enable still lets the high phase run to completion.
          if (cnt_reg == '0) begin
            if (en) start_low = 1'b1;
            else    go_idle   = 1'b1;
          end else begin
            count_down = 1'b1;
          end
        end
        ST_LOW: begin
          if (!en)                 go_idle    = 1'b1;
          else if (cnt_reg == '0)  start_high = 1'b1;
          else                     count_down = 1'b1;
        end
        default: go_idle = 1'b1;
      endcase
    end
  end

  // Shadow moves to active on any rising-edge entry, or straight away when idle.
  assign apply_shadow  = shd_full_reg && (start_high || idle_apply);
  assign restart_sigma = apply_shadow || (sync && en);

  assign ph_half       = apply_shadow  ? shd_half_reg : act_half_reg;
  assign ph_num        = apply_shadow  ? shd_num_reg  : act_num_reg;
  assign ph_den        = apply_shadow  ? shd_den_reg  : act_den_reg;
  assign ph_sigma_base = restart_sigma ? '0 : sigma_reg;

  // One sigma-delta step: extend the phase by a cycle whenever the
  // accumulated fraction reaches a whole input cycle.
  assign ph_sum   = {1'b0, ph_sigma_base} + {1'b0, ph_num};
  assign ph_ext   = (ph_sum >= {1'b0, ph_den});
  assign ph_sigma = ph_ext ? (ph_sum[FRAC_W-1:0] - ph_den) : ph_sum[FRAC_W-1:0];
  assign ph_cnt   = ph_ext ? ph_half : (ph_half - HALF_W'(1));

  // Next-state values for FSM, counter, accumulator and ratio registers.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    sigma_next    = sigma_reg;
    act_half_next = act_half_reg;
    act_num_next  = act_num_reg;
    act_den_next  = act_den_reg;
    shd_half_next = shd_half_reg;
    shd_num_next  = shd_num_reg;
    shd_den_next  = shd_den_reg;
    shd_full_next = shd_full_reg;

    if (apply_shadow) begin
      act_half_next = shd_half_reg;
      act_num_next  = shd_num_reg;
      act_den_next  = shd_den_reg;
      shd_full_next = 1'b0;
    end
    // Writes only arrive while the shadow is empty, so they never collide
    // with an apply.
    if (wr) begin
      shd_half_next = wr_half;
      shd_num_next  = wr_num;
      shd_den_next  = wr_den;
      shd_full_next = 1'b1;
    end

    if (start_high) begin
      state_next = ST_HIGH;
      cnt_next   = ph_cnt;
      sigma_next = ph_sigma;
    end else if (start_low) begin
      state_next = ST_LOW;
      cnt_next   = ph_cnt;
      sigma_next = ph_sigma;
    end else if (go_idle) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      sigma_next = '0;
    end else if (count_down) begin
      cnt_next   = cnt_reg - HALF_W'(1);
    end
  end

  // State, ratio and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      sigma_reg    <= '0;
      act_half_reg <= HALF_W'(RESET_HALF);
      act_num_reg  <= FRAC_W'(RESET_NUM);
      act_den_reg  <= FRAC_W'(RESET_DEN);
      shd_half_reg <= '0;
      shd_num_reg  <= '0;
      shd_den_reg  <= '0;
      shd_full_reg <= 1'b0;
      clk_out_reg  <= 1'b0;
      rise_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      sigma_reg    <= sigma_next;
      act_half_reg <= act_half_next;
      act_num_reg  <= act_num_next;
      act_den_reg  <= act_den_next;
      shd_half_reg <= shd_half_next;
      shd_num_reg  <= shd_num_next;
      shd_den_reg  <= shd_den_next;
      shd_full_reg <= shd_full_next;
      clk_out_reg  <= (state_next == ST_HIGH);
      rise_reg     <= start_high;
    end
  end

  assign shadow_full = shd_full_reg;
  assign clk_out     = clk_out_reg;
  assign rise_stb    = rise_reg;

endmodule

// File: rtl/sd_clock_divider_mc.sv
// Multi-channel fractional clock generator top level: reset synchroniser,
// config decode with per-channel ready, error pulse, channel array and
// optional global-clock buffering.
// Define SD_CLOCK_DIVIDER_CLKENA_EN to drive each clk_out bit through a
// Cyclone V clkena onto global routing; otherwise clk_out is the raw flop.
module sd_clock_divider_mc
  import sd_clock_divider_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int HALF_W     = 16,
  parameter int FRAC_W     = 16,
  parameter int RESET_HALF = DEFAULT_RESET_HALF,
  parameter int RESET_NUM  = DEFAULT_RESET_NUM,
  parameter int RESET_DEN  = DEFAULT_RESET_DEN,
  localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [HALF_W-1:0]   cfg_half,
  input  logic [FRAC_W-1:0]   cfg_num,
  input  logic [FRAC_W-1:0]   cfg_den,
  output logic                cfg_err,
  input  logic [CHANNELS-1:0] chan_en,
  input  logic                sync,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] rise_stb
);

  logic [1:0]          rst_sync_reg;
  logic                rst_n_int;
  logic [CHANNELS-1:0] chan_hit;
  logic [CHANNELS-1:0] shadow_full;
  logic [CHANNELS-1:0] chan_wr;
  logic [CHANNELS-1:0] clk_raw;
  ratio_cfg_t          cfg_req;
  logic                cfg_fire;
  logic                cfg_ok;
  logic                cfg_err_reg;

  // Reset synchroniser: assert asynchronously, release on the clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n_int = rst_sync_reg[1];

  // Widen the request fields so the shared validity check is width-agnostic.
  always_comb begin
    cfg_req      = '0;
    cfg_req.half = CFG_FIELD_W'(cfg_half);
    cfg_req.num  = CFG_FIELD_W'(cfg_num);
    cfg_req.den  = CFG_FIELD_W'(cfg_den);
  end

  // A channel index that matches no channel is treated as an invalid request.
  assign cfg_ready = ~|(chan_hit & shadow_full);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_ok    = cfg_is_valid(cfg_req) & (|chan_hit);

  // Rejected transfers complete but only raise a one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) cfg_err_reg <= 1'b0;
    else            cfg_err_reg <= cfg_fire & ~cfg_ok;
  end

  assign cfg_err = cfg_err_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_hit[gi] = (cfg_chan == CHAN_W'(gi));
      assign chan_wr[gi]  = cfg_fire & cfg_ok & chan_hit[gi];

      sd_clock_divider_chan #(
        .HALF_W     (HALF_W),
        .FRAC_W     (FRAC_W),
        .RESET_HALF (RESET_HALF),
        .RESET_NUM  (RESET_NUM),
        .RESET_DEN  (RESET_DEN)
      ) u_chan (
        .clk         (clk),
        .rst_n       (rst_n_int),
        .en          (chan_en[gi]),
        .sync        (sync),
        .wr          (chan_wr[gi]),
        .wr_half     (cfg_half),
        .wr_num      (cfg_num),
        .wr_den      (cfg_den),
        .shadow_full (shadow_full[gi]),
        .clk_out     (clk_raw[gi]),
        .rise_stb    (rise_stb[gi])
      );
    end
  endgenerate

`ifdef SD_CLOCK_DIVIDER_CLKENA_EN
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_clkena
      cyclonev_clkena #(
        .clock_type        ("Auto"),
        .ena_register_mode ("always enabled")
      ) u_clkena (
        .inclk  (clk_raw[gi]),
        .ena    (1'b1),
        .outclk (clk_out[gi])
      );
    end
  endgenerate
`else
  assign clk_out = clk_raw;
`endif

endmodule
